// File: rtl/sw_pkg.sv
// sw_pkg: definitions shared by the Smith-Waterman host driver.
// Holds the 2-bit base encoding, the score width and the driver FSM
// state type, so that the buffers, the interface and the top agree.
package sw_pkg;

    // 2-bit nucleotide codes as seen by the scoring core
    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    // Width of the core's max score and of the reported result
    localparam int SCORE_W = 12;

    // Result reported when the core never signals finish
    localparam logic [SCORE_W-1:0] SCORE_TIMEOUT = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } sw_state_t;

endpackage

// File: rtl/sw_seq_driver_if.sv
// sw_seq_driver_if: link between the host driver and the scoring core.
//   sw_valid  : driver -> core, a base pair is present this cycle
//   sw_data_s : driver -> core, query base
//   sw_data_t : driver -> core, target base
//   sw_finish : core -> driver, alignment complete (one-cycle pulse)
//   sw_max    : core -> driver, best score, meaningful while sw_finish=1
// The driver uses the master modport, the core the slave modport.
interface sw_seq_driver_if;
    import sw_pkg::*;

    logic               sw_valid;
    logic [1:0]         sw_data_s;
    logic [1:0]         sw_data_t;
    logic               sw_finish;
    logic [SCORE_W-1:0] sw_max;

    modport master (
        output sw_valid,
        output sw_data_s,
        output sw_data_t,
        input  sw_finish,
        input  sw_max
    );

    modport slave (
        input  sw_valid,
        input  sw_data_s,
        input  sw_data_t,
        output sw_finish,
        output sw_max
    );

endinterface

// File: rtl/sw_seq_buf.sv
// sw_seq_buf: small register file holding one sequence of 2-bit bases.
// One host write port and one asynchronous read port driven by the
// stream counter. Addresses at or beyond DEPTH are treated as outside
// the sequence: writes there are dropped and reads return BASE_A (0),
// which gives the zero padding of a shorter query for free.
//   clk, reset_n : clock and asynchronous active-low reset (clears all)
//   wr_en        : write strobe (already qualified by the caller)
//   wr_addr      : write base index
//   wr_data      : base code to store
//   rd_addr      : read base index
//   rd_data      : base at rd_addr, or 0 when out of range
module sw_seq_buf
    import sw_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;
    // Depth widened by one bit so DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0] mem [SLOTS];
    logic       wr_hit;
    logic       rd_hit;

    assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign rd_hit = ({1'b0, rd_addr} < DEPTH_L);

    // Storage: cleared on reset, written only for in-range addresses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= BASE_A;
            end
        end else if (wr_hit) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = rd_hit ? mem[rd_addr[IDX_W-1:0]] : BASE_A;

endmodule

// File: rtl/sw_seq_driver.sv
// sw_seq_driver: host-side driver for the Smith-Waterman scoring core.
// The host loads a query S and a target T into internal buffers, then
// pulses start. The driver streams LEN_T base pairs to the core (query
// zero-padded past LEN_S), waits for the core's finish pulse, captures
// the max score and reports it with a one-cycle done. If finish does not
// arrive within TIMEOUT cycles the result is all ones and timeout_err
// is raised.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   wr_en/wr_sel   : host buffer write strobe, 0 = S buffer, 1 = T buffer
//   wr_addr/wr_data: base index and base code for the write
//   start          : request an alignment (honoured in IDLE or DONE)
//   busy           : run in progress
//   done           : one-cycle pulse, result valid
//   result         : captured score, held until the next done
//   timeout_err    : the last run ended without a finish from the core
//   core           : stream/result link to the scoring core (master side)
module sw_seq_driver
    import sw_pkg::*;
#(
    parameter int LEN_S   = 16,
    parameter int LEN_T   = 48,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [1:0]         wr_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] result,
    output logic               timeout_err,
    sw_seq_driver_if.master    core
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(LEN_T - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    sw_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               busy_d;
    logic               done_d;
    logic [SCORE_W-1:0] result_d;
    logic               terr_d;
    logic               valid_q, valid_d;
    logic [1:0]         data_s_q, data_s_d;
    logic [1:0]         data_t_q, data_t_d;

    logic               host_wr_ok;
    logic [ADDR_W-1:0]  rd_idx;
    logic [1:0]         rd_s;
    logic [1:0]         rd_t;

    // Buffers are frozen for the whole run
    assign host_wr_ok = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Outputs are registered, so the buffers are read one base ahead:
    // base 0 when a start is being accepted, base k+1 while streaming base k.
    assign rd_idx = (state_q == ST_STREAM) ? (k_q + ADDR_W'(1)) : '0;

    sw_seq_buf #(
        .DEPTH  (LEN_S),
        .ADDR_W (ADDR_W)
    ) u_buf_s (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (host_wr_ok && !wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_idx),
        .rd_data (rd_s)
    );

    sw_seq_buf #(
        .DEPTH  (LEN_T),
        .ADDR_W (ADDR_W)
    ) u_buf_t (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (host_wr_ok && wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_idx),
        .rd_data (rd_t)
    );

    // Next-state and next-output logic; the stream data returns to 0
    // whenever sw_valid is low.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wait_d   = wait_q;
        busy_d   = busy;
        done_d   = 1'b0;
        result_d = result;
        terr_d   = timeout_err;
        valid_d  = 1'b0;
        data_s_d = BASE_A;
        data_t_d = BASE_A;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (start) begin
                    state_d  = ST_STREAM;
                    k_d      = '0;
                    busy_d   = 1'b1;
                    terr_d   = 1'b0;
                    valid_d  = 1'b1;
                    data_s_d = rd_s;
                    data_t_d = rd_t;
                end
            end

            ST_STREAM: begin
                if (k_q == LAST_K) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end else begin
                    k_d      = k_q + ADDR_W'(1);
                    valid_d  = 1'b1;
                    data_s_d = rd_s;
                    data_t_d = rd_t;
                end
            end

            ST_WAIT: begin
                // A finish in the timeout cycle still counts as a real result
                if (core.sw_finish) begin
                    state_d  = ST_DONE;
                    result_d = core.sw_max;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = SCORE_TIMEOUT;
                    terr_d   = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wait_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            timeout_err <= 1'b0;
            valid_q     <= 1'b0;
            data_s_q    <= BASE_A;
            data_t_q    <= BASE_A;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            busy        <= busy_d;
            done        <= done_d;
            result      <= result_d;
            timeout_err <= terr_d;
            valid_q     <= valid_d;
            data_s_q    <= data_s_d;
            data_t_q    <= data_t_d;
        end
    end

    assign core.sw_valid  = valid_q;
    assign core.sw_data_s = data_s_q;
    assign core.sw_data_t = data_t_q;

endmodule

// File: tb/tb_sw_seq_driver.sv
// tb_sw_seq_driver: directed bench for sw_seq_driver. A stream table of
// expected per-cycle core-side values is built up front and replayed for
// each run; hand-written sequences cover result capture, timeout,
// back-to-back start and asynchronous reset.
module tb_sw_seq_driver;
    import sw_pkg::*;

    localparam int LEN_S   = 16;
    localparam int LEN_T   = 48;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 4096;
    localparam int NVEC    = LEN_T + 1;

    logic               clk;
    logic               reset_n;
    logic               wr_en;
    logic               wr_sel;
    logic [ADDR_W-1:0]  wr_addr;
    logic [1:0]         wr_data;
    logic               start;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] result;
    logic               timeout_err;

    sw_seq_driver_if core_if();

    sw_seq_driver #(
        .LEN_S   (LEN_S),
        .LEN_T   (LEN_T),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .timeout_err (timeout_err),
        .core        (core_if)
    );

    // One row per stream cycle: inject code is a host disturbance to apply
    // in that cycle (0 none, 1 start + T write, 2 start + S write).
    typedef struct {
        int         cycle;
        int         inject;
        logic       exp_valid;
        logic [1:0] exp_s;
        logic [1:0] exp_t;
    } stream_vec_t;

    stream_vec_t vec [NVEC];
    int checks = 0;
    int passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One host buffer write cycle
    task automatic applyStimulus(input logic sel, input int addr, input logic [1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pulse start and compare every stream cycle plus the first WAIT cycle.
    // Returns positioned in WAIT cycle 1.
    task automatic runStreamTable(input bit inject);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_run_start", busy, 1);
        checkOutput("terr_run_start", timeout_err, 0);
        for (int i = 0; i < NVEC; i++) begin
            checkOutput($sformatf("valid_k%0d", vec[i].cycle), core_if.sw_valid, vec[i].exp_valid);
            checkOutput($sformatf("data_s_k%0d", vec[i].cycle), core_if.sw_data_s, vec[i].exp_s);
            checkOutput($sformatf("data_t_k%0d", vec[i].cycle), core_if.sw_data_t, vec[i].exp_t);
            if (inject && vec[i].inject == 1) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd10; wr_data = 2'd0;
            end else if (inject && vec[i].inject == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd12; wr_data = 2'd2;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    initial begin
        int cnt;

        for (int k = 0; k < NVEC; k++) begin
            vec[k].cycle     = k;
            vec[k].inject    = (k == 5) ? 1 : ((k == 6) ? 2 : 0);
            vec[k].exp_valid = (k < LEN_T);
            vec[k].exp_t     = (k < LEN_T) ? 2'((k + 1) % 4) : 2'd0;
            vec[k].exp_s     = (k < LEN_S) ? 2'(k % 4) : 2'd0;
        end

        reset_n = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        core_if.sw_finish = 1'b0;
        core_if.sw_max    = '0;

        tick(); tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_terr", timeout_err, 0);
        checkOutput("rst_valid", core_if.sw_valid, 0);
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_valid", core_if.sw_valid, 0);
        checkOutput("post_rst_data_t", core_if.sw_data_t, 0);

        for (int i = 0; i < LEN_S; i++) applyStimulus(1'b0, i, 2'(i % 4));
        for (int i = 0; i < LEN_T; i++) applyStimulus(1'b1, i, 2'((i + 1) % 4));
        applyStimulus(1'b0, 20, 2'd3);

        // finish while idle must not produce a done or change result
        core_if.sw_finish = 1'b1; core_if.sw_max = 12'd99;
        tick();
        core_if.sw_finish = 1'b0; core_if.sw_max = '0;
        checkOutput("idle_finish_done", done, 0);
        checkOutput("idle_finish_result", result, 0);

        $display("[TB] run 1: stream with start/write injection");
        runStreamTable(1'b1);
        for (int w = 1; w < 10; w++) begin
            start = (w == 2);
            tick();
        end
        start = 1'b0;
        checkOutput("wait_busy", busy, 1);
        checkOutput("wait_done", done, 0);
        checkOutput("wait_valid", core_if.sw_valid, 0);
        core_if.sw_finish = 1'b1; core_if.sw_max = 12'd37;
        tick();
        core_if.sw_finish = 1'b0; core_if.sw_max = '0;
        checkOutput("cap_done", done, 1);
        checkOutput("cap_busy", busy, 0);
        checkOutput("cap_result", result, 37);
        checkOutput("cap_terr", timeout_err, 0);
        tick();
        checkOutput("cap_done_pulse", done, 0);
        checkOutput("cap_result_hold", result, 37);

        $display("[TB] run 2: core never finishes");
        runStreamTable(1'b0);
        cnt = 1;
        while (done !== 1'b1 && cnt < TIMEOUT + 200) begin
            tick();
            cnt++;
        end
        checkOutput("to_cycles", cnt, TIMEOUT);
        checkOutput("to_done", done, 1);
        checkOutput("to_result", result, 12'hFFF);
        checkOutput("to_terr", timeout_err, 1);
        checkOutput("to_busy", busy, 0);
        tick();
        checkOutput("to_terr_hold", timeout_err, 1);
        checkOutput("to_done_pulse", done, 0);

        $display("[TB] run 3: identical data, then back-to-back start");
        runStreamTable(1'b0);
        core_if.sw_finish = 1'b1; core_if.sw_max = 12'd37;
        tick();
        core_if.sw_finish = 1'b0; core_if.sw_max = '0;
        checkOutput("r3_done", done, 1);
        checkOutput("r3_result", result, 37);
        checkOutput("r3_terr", timeout_err, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("b2b_valid", core_if.sw_valid, 1);
        checkOutput("b2b_data_t", core_if.sw_data_t, 1);
        checkOutput("b2b_data_s", core_if.sw_data_s, 0);
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_done", done, 0);
        repeat (5) tick();
        checkOutput("b2b_k5_data_t", core_if.sw_data_t, 2);

        // asynchronous reset in the middle of the stream
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_valid", core_if.sw_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_data_t", core_if.sw_data_t, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        checkOutput("arst_idle_valid", core_if.sw_valid, 0);
        checkOutput("arst_idle_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("clr_valid", core_if.sw_valid, 1);
        checkOutput("clr_t0", core_if.sw_data_t, 0);
        checkOutput("clr_s0", core_if.sw_data_s, 0);
        tick();
        checkOutput("clr_t1", core_if.sw_data_t, 0);
        checkOutput("clr_s1", core_if.sw_data_s, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
